// File: rtl/enabled_register_bank_if.sv
// rtl/enabled_register_bank_if.sv - write/read/clear bus of the enabled register bank (commit present with SHADOW_COMMIT_EN)
interface enabled_register_bank_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic             clear;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic [WIDTH/8-1:0] wr_mask;
  logic             wr_err;
  logic             rd_en;
  logic [AW-1:0]    rd_addr;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid;
`ifdef SHADOW_COMMIT_EN
  logic             commit;

  modport master (
    output clear, wr_en, wr_addr, wr_data, wr_mask, rd_en, rd_addr, commit,
    input  wr_err, rd_data, rd_valid
  );
  modport slave (
    input  clear, wr_en, wr_addr, wr_data, wr_mask, rd_en, rd_addr, commit,
    output wr_err, rd_data, rd_valid
  );
`else
  modport master (
    output clear, wr_en, wr_addr, wr_data, wr_mask, rd_en, rd_addr,
    input  wr_err, rd_data, rd_valid
  );
  modport slave (
    input  clear, wr_en, wr_addr, wr_data, wr_mask, rd_en, rd_addr,
    output wr_err, rd_data, rd_valid
  );
`endif
endinterface

// File: rtl/enabled_register_bank.sv
// rtl/enabled_register_bank.sv - DEPTH x WIDTH register bank, byte-masked writes, registered reads, optional SHADOW_COMMIT_EN shadow copy
module enabled_register_bank #(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input logic                  clk,
  input logic                  reset_n,
  enabled_register_bank_if.slave bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int NL = WIDTH / 8;
  // One extra bit so DEPTH == 2**AW is representable in the range compare.
  localparam logic [AW:0] LP_DEPTH = (AW + 1)'(DEPTH);

  generate
    if ((WIDTH < 8) || ((WIDTH % 8) != 0)) begin : g_bad_width
      $error("enabled_register_bank: WIDTH must be a non-zero multiple of 8");
    end
    if (DEPTH < 1) begin : g_bad_depth
      $error("enabled_register_bank: DEPTH must be at least 1");
    end
  endgenerate

  logic [WIDTH-1:0] r_act [DEPTH];
  logic [WIDTH-1:0] w_next [DEPTH];
  logic             w_wr_in_range;
  logic             w_rd_in_range;
  logic             r_wr_err;
  logic             r_rd_valid;
  logic [WIDTH-1:0] r_rd_data;

  assign w_wr_in_range = ({1'b0, bus.wr_addr} < LP_DEPTH);
  assign w_rd_in_range = ({1'b0, bus.rd_addr} < LP_DEPTH);

`ifdef SHADOW_COMMIT_EN
  logic [WIDTH-1:0] r_shd [DEPTH];

  // Masked write merged into the shadow copy; this is also what a commit publishes.
  always_comb begin
    for (int e = 0; e < DEPTH; e++) begin
      w_next[e] = r_shd[e];
      if (bus.wr_en && w_wr_in_range && (bus.wr_addr == AW'(e))) begin
        for (int l = 0; l < NL; l++) begin
          if (bus.wr_mask[l]) begin
            w_next[e][8*l +: 8] = bus.wr_data[8*l +: 8];
          end
        end
      end
    end
  end

  // Shadow takes every write; active copy only changes on commit; clear wins over both.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int e = 0; e < DEPTH; e++) begin
        r_shd[e] <= RESET_VAL;
        r_act[e] <= RESET_VAL;
      end
    end else if (bus.clear) begin
      for (int e = 0; e < DEPTH; e++) begin
        r_shd[e] <= RESET_VAL;
        r_act[e] <= RESET_VAL;
      end
    end else begin
      for (int e = 0; e < DEPTH; e++) begin
        r_shd[e] <= w_next[e];
        if (bus.commit) begin
          r_act[e] <= w_next[e];
        end
      end
    end
  end
`else
  // Masked write merged into the live entries.
  always_comb begin
    for (int e = 0; e < DEPTH; e++) begin
      w_next[e] = r_act[e];
      if (bus.wr_en && w_wr_in_range && (bus.wr_addr == AW'(e))) begin
        for (int l = 0; l < NL; l++) begin
          if (bus.wr_mask[l]) begin
            w_next[e][8*l +: 8] = bus.wr_data[8*l +: 8];
          end
        end
      end
    end
  end

  // Entry storage; clear drops any same-cycle write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int e = 0; e < DEPTH; e++) begin
        r_act[e] <= RESET_VAL;
      end
    end else if (bus.clear) begin
      for (int e = 0; e < DEPTH; e++) begin
        r_act[e] <= RESET_VAL;
      end
    end else begin
      for (int e = 0; e < DEPTH; e++) begin
        r_act[e] <= w_next[e];
      end
    end
  end
`endif

  // Registered read of the pre-edge active value, plus out-of-range write error pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_wr_err   <= 1'b0;
    end else begin
      r_rd_valid <= bus.rd_en;
      r_wr_err   <= bus.wr_en && !w_wr_in_range;
      if (bus.rd_en) begin
        r_rd_data <= w_rd_in_range ? r_act[bus.rd_addr] : '0;
      end
    end
  end

  assign bus.rd_data  = r_rd_data;
  assign bus.rd_valid = r_rd_valid;
  assign bus.wr_err   = r_wr_err;
endmodule

// File: tb/tb_enabled_register_bank.sv
// tb/tb_enabled_register_bank.sv - scoreboard bench for enabled_register_bank (WIDTH=16, DEPTH=3)
module tb_enabled_register_bank;
  localparam int          W  = 16;
  localparam int          D  = 3;
  localparam logic [15:0] RV = 16'hC3A5;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  enabled_register_bank_if #(.WIDTH(W), .DEPTH(D)) bus ();

  enabled_register_bank #(.WIDTH(W), .DEPTH(D), .RESET_VAL(RV)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  typedef struct {
    int          tag;
    logic [15:0] data;
  } rd_exp_t;

  rd_exp_t rd_q[$];
  int      err_q[$];

  // Reference state: what a reader sees, and (shadow build) what is pending.
  logic [15:0] m_act [D];
  logic [15:0] m_sh  [D];

  task automatic model_reset();
    for (int i = 0; i < D; i++) begin
      m_act[i] = RV;
      m_sh[i]  = RV;
    end
    rd_q.delete();
    err_q.delete();
  endtask

  // Apply one cycle of stimulus and record what the next edge must produce.
  task automatic drive(input bit we, input logic [1:0] wa, input logic [15:0] wd,
                       input logic [1:0] wm, input bit re, input logic [1:0] ra,
                       input bit clr, input bit cmt);
    logic [15:0] tgt [D];
    rd_exp_t     r;
    @(posedge clk);
    #1;
    bus.wr_en   = we;
    bus.wr_addr = wa;
    bus.wr_data = wd;
    bus.wr_mask = wm;
    bus.rd_en   = re;
    bus.rd_addr = ra;
    bus.clear   = clr;
`ifdef SHADOW_COMMIT_EN
    bus.commit  = cmt;
`endif
    if (re) begin
      r.tag  = cyc + 1;
      r.data = (int'(ra) < D) ? m_act[ra] : 16'h0000;
      rd_q.push_back(r);
    end
    if (we && int'(wa) >= D) err_q.push_back(cyc + 1);
`ifdef SHADOW_COMMIT_EN
    for (int i = 0; i < D; i++) tgt[i] = m_sh[i];
`else
    for (int i = 0; i < D; i++) tgt[i] = m_act[i];
`endif
    if (we && int'(wa) < D) begin
      if (wm[0]) tgt[wa][7:0]  = wd[7:0];
      if (wm[1]) tgt[wa][15:8] = wd[15:8];
    end
    if (clr) begin
      for (int i = 0; i < D; i++) begin
        m_act[i] = RV;
        m_sh[i]  = RV;
      end
    end else begin
`ifdef SHADOW_COMMIT_EN
      for (int i = 0; i < D; i++) m_sh[i] = tgt[i];
      if (cmt) for (int i = 0; i < D; i++) m_act[i] = tgt[i];
`else
      for (int i = 0; i < D; i++) m_act[i] = tgt[i];
      if (cmt) m_sh[0] = m_sh[0];
`endif
    end
  endtask

  task automatic idle();
    drive(0, 2'd0, 16'h0, 2'b00, 0, 2'd0, 0, 0);
  endtask

  task automatic rd(input logic [1:0] a);
    drive(0, 2'd0, 16'h0, 2'b00, 1, a, 0, 0);
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d, input logic [1:0] m);
    drive(1, a, d, m, 0, 2'd0, 0, 0);
  endtask

  task automatic read_all();
    for (int a = 0; a < 4; a++) rd(2'(a));
  endtask

  // Monitor: checks reset-time quiet outputs and pops the scoreboard on each pulse.
  always @(negedge clk) begin
    if (!reset_n) begin
      total++;
      if (bus.rd_valid !== 1'b0 || bus.wr_err !== 1'b0) begin
        bad++;
        $display("FAIL reset_quiet: rd_valid=%b wr_err=%b, required 0 0", bus.rd_valid, bus.wr_err);
      end
    end else begin
      while (rd_q.size() > 0 && rd_q[0].tag < cyc) begin
        total++;
        bad++;
        $display("FAIL rd_missing: no rd_valid at cycle %0d, required data %h", rd_q[0].tag, rd_q[0].data);
        void'(rd_q.pop_front());
      end
      if (bus.rd_valid !== 1'b0) begin
        total++;
        if (rd_q.size() == 0 || rd_q[0].tag != cyc) begin
          bad++;
          $display("FAIL rd_unexpected: rd_valid=%b data=%h at cycle %0d, required no read", bus.rd_valid, bus.rd_data, cyc);
        end else begin
          rd_exp_t e;
          e = rd_q.pop_front();
          if (bus.rd_data !== e.data) begin
            bad++;
            $display("FAIL rd_data: got %h at cycle %0d, required %h", bus.rd_data, cyc, e.data);
          end
        end
      end
      while (err_q.size() > 0 && err_q[0] < cyc) begin
        total++;
        bad++;
        $display("FAIL wr_err_missing: no pulse at cycle %0d, required 1", err_q[0]);
        void'(err_q.pop_front());
      end
      if (bus.wr_err !== 1'b0) begin
        total++;
        if (err_q.size() == 0 || err_q[0] != cyc) begin
          bad++;
          $display("FAIL wr_err_unexpected: wr_err=%b at cycle %0d, required 0", bus.wr_err, cyc);
        end else begin
          void'(err_q.pop_front());
        end
      end
    end
  end

  initial begin
    bus.wr_en = 0; bus.wr_addr = 0; bus.wr_data = 0; bus.wr_mask = 0;
    bus.rd_en = 0; bus.rd_addr = 0; bus.clear = 0;
`ifdef SHADOW_COMMIT_EN
    bus.commit = 0;
`endif
    model_reset();
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // Reset values and out-of-range read returning zero.
    read_all();

    // Byte-lane merge: 0xABCD full, then 0x1234 low lane only -> 0xAB34.
    wr(2'd1, 16'hABCD, 2'b11);
    wr(2'd1, 16'h1234, 2'b01);
    rd(2'd1);
    wr(2'd2, 16'hFFFF, 2'b00);
    rd(2'd2);

    // Out-of-range write: single error pulse, nothing changes.
    wr(2'd3, 16'hFFFF, 2'b11);
    idle();
    wr(2'd3, 16'h0F0F, 2'b11);
    wr(2'd3, 16'hF0F0, 2'b10);
    read_all();

    // Read-before-write on the same entry.
    wr(2'd0, 16'h0000, 2'b11);
    drive(1, 2'd0, 16'h0055, 2'b11, 1, 2'd0, 0, 0);
    rd(2'd0);

    // Clear beats a same-cycle write; error still reported for out-of-range.
    wr(2'd2, 16'h1111, 2'b11);
    drive(1, 2'd2, 16'h2222, 2'b11, 1, 2'd2, 1, 0);
    drive(1, 2'd3, 16'h3333, 2'b11, 0, 2'd0, 1, 0);
    read_all();

`ifdef SHADOW_COMMIT_EN
    // Shadow/commit: writes invisible until commit; write+commit is included.
    wr(2'd2, 16'h0077, 2'b11);
    rd(2'd2);
    drive(0, 2'd0, 16'h0, 2'b00, 1, 2'd2, 0, 1);
    rd(2'd2);
    drive(1, 2'd0, 16'h1111, 2'b11, 0, 2'd0, 0, 1);
    rd(2'd0);
    wr(2'd1, 16'h4444, 2'b11);
    drive(0, 2'd0, 16'h0, 2'b00, 0, 2'd0, 1, 1);
    drive(0, 2'd0, 16'h0, 2'b00, 0, 2'd0, 0, 1);
    read_all();
`endif

    // Randomized traffic against the reference model.
    for (int n = 0; n < 400; n++) begin
      drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 16'($urandom),
            2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) == 0));
    end

    // Reset asserted in the middle of a write burst.
    for (int n = 0; n < 3; n++) wr(2'(n), 16'($urandom), 2'b11);
    @(posedge clk);
    #1;
    bus.wr_en = 1; bus.wr_addr = 2'd1; bus.wr_data = 16'hDEAD; bus.wr_mask = 2'b11;
    bus.rd_en = 1; bus.rd_addr = 2'd1;
    reset_n = 1'b0;
    model_reset();
    for (int n = 0; n < 3; n++) begin
      @(posedge clk);
      #1 bus.wr_addr = 2'(n); bus.wr_data = 16'($urandom);
    end
    bus.wr_en = 0; bus.rd_en = 0;
    reset_n = 1'b1;
    read_all();

    repeat (3) idle();
    @(posedge clk);
    @(negedge clk);
    total++;
    if (rd_q.size() != 0 || err_q.size() != 0) begin
      bad++;
      $display("FAIL drain: rd pending=%0d err pending=%0d, required 0 0", rd_q.size(), err_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
